matvec_host_ctrl: RTL and testbench
===================================

# matvec_host_ctrl

Host-side controller for the matrix-vector multiply engine. It accepts a job as a byte stream: the matrix row-major, then the vector. It drives the engine's `a_matrix`, `b_vector` and `mult_valid`, waits for `done`, and streams the `DEPTH` results back out over a valid/ready word interface. It also owns the engine's reset, because the engine only leaves its done state through reset.

## Interface
Parameters:
- `DEPTH`, 8: matrix dimension and vector length.
- `DATA_WIDTH`, 8: element width.
- `RESULT_WIDTH`, 24: result word width; matches the engine's `c_vector`.

Ports:
- `clk`  in  1  single clock; all logic on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  input byte valid.
- `in_ready`  out  1  controller can accept a byte.
- `in_data`  in  DATA_WIDTH  input element.
- `a_matrix`  out  DATA_WIDTH x [0:DEPTH-1][0:DEPTH-1]  registered matrix to engine.
- `b_vector`  out  DATA_WIDTH x [0:DEPTH-1]  registered vector to engine.
- `mult_valid`  out  1  start strobe to engine.
- `done`  in  1  engine completion level.
- `c_vector`  in  RESULT_WIDTH x [0:DEPTH-1]  engine results.
- `eng_rst_n`  out  1  active-low reset for the engine.
- `out_valid`  out  1  result word valid.
- `out_ready`  in  1  downstream accepts word.
- `out_data`  out  RESULT_WIDTH  result word.
- `out_last`  out  1  marks the final word of a job.

## Operation
- The FSM has six states: LOAD_A, LOAD_B, START, WAIT, DRAIN, ENG_RST.
- **Reset state:** the FSM is in LOAD_A with the index counter at 0. The matrix, vector and result snapshot registers are 0.
- **LOAD_A:**
  - `in_ready`=1.
  - On each handshake (`in_valid && in_ready`), byte k is written to `a_matrix[k/DEPTH][k%DEPTH]`.
  - After byte `DEPTH*DEPTH-1` the FSM moves to LOAD_B and the index resets to 0.
- **LOAD_B:**
  - `in_ready`=1.
  - Byte k is written to `b_vector[k]`.
  - After byte `DEPTH-1` the FSM moves to START.
- **START:** `mult_valid`=1 for exactly one cycle, then WAIT.
- **WAIT:**
  - `in_ready`=0.
  - On `done`=1, snapshot all `c_vector` entries into internal result registers, then go to DRAIN with the index at 0.
  - `done` is ignored in every other state.
- **DRAIN:**
  - `out_valid`=1 and `out_data`=result[index].
  - `out_last`=1 when index=`DEPTH-1`.
  - On each `out_ready` handshake the index increments.
  - After the last handshake the FSM moves to ENG_RST.
- **ENG_RST:**
  - `eng_rst_n`=0 for exactly 2 cycles, then LOAD_A.
- **Stability while the engine runs:** `a_matrix` and `b_vector` hold their values from START until the next LOAD_A write.
- **Engine reset output:** `eng_rst_n` = `rst_n` AND NOT (state==ENG_RST). It is therefore also low during global reset.
- **Reset mid-operation:** everything returns to the reset state and any partial job is discarded. The next byte after reset is `a_matrix[0][0]`.
- **Counter widths:** the index counter is $clog2(DEPTH*DEPTH) bits wide and never wraps mid-phase.

## Timing
- **Output values under reset:**
  - `in_ready`=1
  - `mult_valid`=0
  - `eng_rst_n`=0
  - `out_valid`=0
  - `out_data`=0
  - `out_last`=0
  - `a_matrix`/`b_vector`=0
- **Load-to-start latency:** `mult_valid` rises on the cycle after the final B handshake.
- **Done-to-output latency:** `out_valid` rises on the cycle after `done` is sampled high in WAIT.
- **Output hold rule:** while `out_valid && !out_ready`, `out_data` and `out_last` hold stable.
- **Back-to-back output:** with `out_ready` held high, one word per cycle.
- **Input throughput:** with `in_valid` held high, one byte per cycle; gaps in `in_valid` stall without loss.
- **Restart latency:** `in_ready` returns 1 exactly 2 cycles after the last output handshake.

## Configuration
- `MATVEC_SUM_EN` defined:
  - DRAIN emits `DEPTH+1` words.
  - Word `DEPTH` is the sum of all `DEPTH` snapshot results, truncated to `RESULT_WIDTH`.
  - `out_last` is on that sum word only.
- `MATVEC_SUM_EN` undefined: DRAIN emits `DEPTH` words and no summing logic is built.

## Test plan
- **Identity job:** identity matrix and b=1..8, `done` asserted 20 cycles after `mult_valid` with c_vector=1..8 → `out_data` 1,2,…,8, `out_last` only on 8; with `MATVEC_SUM_EN`, a 9th word of 36 carries `out_last`.
- **Max values:** all elements 0xFF, engine model returns 0x07F008 for each entry → eight words of 0x07F008; sum word 0x3F8040.
- **Output backpressure:** toggle `out_ready` pseudo-randomly → no word dropped or duplicated; `out_data` stable while stalled.
- **Input gaps:** insert random `in_valid` gaps during load → `a_matrix[r][c]` equals byte r*8+c; `mult_valid` is one pulse, one cycle after the 72nd handshake.
- **Reset mid-load:** assert `rst_n` low after 10 bytes, then send a fresh 72 bytes → the new job loads correctly and no stale data is output.
- **Two back-to-back jobs:** run two jobs in sequence → `eng_rst_n` low exactly 2 cycles between them; the second job's results are correct; `done` arriving outside WAIT is ignored.

Source files
------------

// File: rtl/matvec_host_ctrl.sv
// Host-side controller for the matrix-vector engine: loads A then b from a byte stream, starts the
// engine, snapshots results, drains them as words and pulses the engine reset. Option: MATVEC_SUM_EN.
module matvec_host_ctrl #(
  parameter int unsigned DEPTH        = 8,
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned RESULT_WIDTH = 24
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_WIDTH-1:0]   in_data,
  output logic [DATA_WIDTH-1:0]   a_matrix [0:DEPTH-1][0:DEPTH-1],
  output logic [DATA_WIDTH-1:0]   b_vector [0:DEPTH-1],
  output logic                    mult_valid,
  input  logic                    done,
  input  logic [RESULT_WIDTH-1:0] c_vector [0:DEPTH-1],
  output logic                    eng_rst_n,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [RESULT_WIDTH-1:0] out_data,
  output logic                    out_last
);

  localparam int unsigned IdxW = (DEPTH * DEPTH > 1) ? $clog2(DEPTH * DEPTH) : 1;
  localparam logic [IdxW-1:0] LastA = IdxW'(DEPTH * DEPTH - 1);
  localparam logic [IdxW-1:0] LastB = IdxW'(DEPTH - 1);
`ifdef MATVEC_SUM_EN
  localparam logic [IdxW-1:0] LastOut = IdxW'(DEPTH);
`else
  localparam logic [IdxW-1:0] LastOut = IdxW'(DEPTH - 1);
`endif

  typedef enum logic [2:0] {StLoadA, StLoadB, StStart, StWait, StDrain, StEngRst} state_e;

  state_e                  state;
  logic [IdxW-1:0]         idx;
  logic [RESULT_WIDTH-1:0] result [0:DEPTH-1];

`ifdef MATVEC_SUM_EN
  logic [RESULT_WIDTH-1:0] sum;
  logic [RESULT_WIDTH-1:0] sum_c;

  // Truncating sum of the live engine results, captured alongside the snapshot.
  always_comb begin
    sum_c = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      sum_c = sum_c + c_vector[i];
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= StLoadA;
      idx   <= '0;
      for (int unsigned r = 0; r < DEPTH; r++) begin
        b_vector[r] <= '0;
        result[r]   <= '0;
        for (int unsigned c = 0; c < DEPTH; c++) begin
          a_matrix[r][c] <= '0;
        end
      end
`ifdef MATVEC_SUM_EN
      sum <= '0;
`endif
    end else begin
      unique case (state)
        StLoadA: begin
          if (in_valid) begin
            for (int unsigned r = 0; r < DEPTH; r++) begin
              for (int unsigned c = 0; c < DEPTH; c++) begin
                if (idx == IdxW'(r * DEPTH + c)) a_matrix[r][c] <= in_data;
              end
            end
            if (idx == LastA) begin
              idx   <= '0;
              state <= StLoadB;
            end else begin
              idx <= idx + IdxW'(1);
            end
          end
        end
        StLoadB: begin
          if (in_valid) begin
            for (int unsigned r = 0; r < DEPTH; r++) begin
              if (idx == IdxW'(r)) b_vector[r] <= in_data;
            end
            if (idx == LastB) begin
              idx   <= '0;
              state <= StStart;
            end else begin
              idx <= idx + IdxW'(1);
            end
          end
        end
        StStart: state <= StWait;
        StWait: begin
          if (done) begin
            for (int unsigned r = 0; r < DEPTH; r++) begin
              result[r] <= c_vector[r];
            end
`ifdef MATVEC_SUM_EN
            sum <= sum_c;
`endif
            idx   <= '0;
            state <= StDrain;
          end
        end
        StDrain: begin
          if (out_ready) begin
            if (idx == LastOut) begin
              idx   <= '0;
              state <= StEngRst;
            end else begin
              idx <= idx + IdxW'(1);
            end
          end
        end
        StEngRst: begin
          // idx counts the two engine-reset cycles
          if (idx == IdxW'(1)) begin
            idx   <= '0;
            state <= StLoadA;
          end else begin
            idx <= idx + IdxW'(1);
          end
        end
        default: state <= StLoadA;
      endcase
    end
  end

  always_comb begin
    in_ready   = (state == StLoadA) || (state == StLoadB);
    mult_valid = (state == StStart);
    out_valid  = (state == StDrain);
    out_last   = out_valid && (idx == LastOut);
    out_data   = '0;
    if (out_valid) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (idx == IdxW'(i)) out_data = result[i];
      end
`ifdef MATVEC_SUM_EN
      if (idx == IdxW'(DEPTH)) out_data = sum;
`endif
    end
  end

  assign eng_rst_n = rst_n & (state != StEngRst);

endmodule

// File: tb/tb_matvec_host_ctrl.sv
// Directed bench for matvec_host_ctrl: engine model plus a scoreboard of expected result words.
module tb_matvec_host_ctrl;

  localparam int unsigned D  = 8;
  localparam int unsigned DW = 8;
  localparam int unsigned RW = 24;
  localparam int unsigned NBYTES = D * D + D;
`ifdef MATVEC_SUM_EN
  localparam bit SumEn = 1'b1;
`else
  localparam bit SumEn = 1'b0;
`endif
  localparam int unsigned NWORDS = SumEn ? D + 1 : D;

  logic          clk = 1'b0;
  logic          rst_n, in_valid, in_ready, mult_valid, done, eng_rst_n;
  logic          out_valid, out_ready, out_last, done_force;
  logic [DW-1:0] in_data;
  logic [DW-1:0] a_matrix [0:D-1][0:D-1];
  logic [DW-1:0] b_vector [0:D-1];
  logic [RW-1:0] c_vector [0:D-1];
  logic [RW-1:0] out_data;

  logic          eng_done, eng_busy;
  int unsigned   eng_cnt;

  typedef struct {
    logic [RW-1:0] d;
    logic          l;
  } exp_t;
  exp_t          exp_q [$];
  logic [DW-1:0] job_bytes [0:NBYTES-1];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  matvec_host_ctrl #(.DEPTH(D), .DATA_WIDTH(DW), .RESULT_WIDTH(RW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .a_matrix   (a_matrix),
    .b_vector   (b_vector),
    .mult_valid (mult_valid),
    .done       (done),
    .c_vector   (c_vector),
    .eng_rst_n  (eng_rst_n),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_last   (out_last)
  );

  assign done = eng_done | done_force;

  function automatic logic [RW-1:0] eng_dot(input int unsigned i);
    int unsigned acc = 0;
    for (int unsigned j = 0; j < D; j++) acc += a_matrix[i][j] * b_vector[j];
    return RW'(acc);
  endfunction

  // Engine model: latches A*b on mult_valid, raises done 20 cycles later, cleared only by reset.
  always @(posedge clk or negedge eng_rst_n) begin
    if (!eng_rst_n) begin
      eng_done <= 1'b0;
      eng_busy <= 1'b0;
      eng_cnt  <= 0;
      for (int i = 0; i < D; i++) c_vector[i] <= '0;
    end else if (mult_valid && !eng_busy) begin
      eng_busy <= 1'b1;
      eng_cnt  <= 0;
      for (int i = 0; i < D; i++) c_vector[i] <= eng_dot(i);
    end else if (eng_busy && !eng_done) begin
      eng_cnt <= eng_cnt + 1;
      if (eng_cnt == 19) eng_done <= 1'b1;
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: observed no finish, expected finish before 2ms");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push_expected();
    exp_t          e;
    logic [RW-1:0] s = '0;
    for (int unsigned i = 0; i < D; i++) begin
      int unsigned acc = 0;
      for (int unsigned j = 0; j < D; j++) acc += job_bytes[i*D+j] * job_bytes[D*D+j];
      e.d = RW'(acc);
      e.l = !SumEn && (i == D - 1);
      exp_q.push_back(e);
      s = s + e.d;
    end
    if (SumEn) begin
      e.d = s;
      e.l = 1'b1;
      exp_q.push_back(e);
    end
  endtask

  // Starts and ends on a falling edge; leaves the DUT in WAIT.
  task automatic send_job(input bit gaps, input bit pulse);
    chk("load_in_ready", in_ready, 1);
    for (int k = 0; k < NBYTES; k++) begin
      if (gaps) begin
        while ($urandom_range(0, 2) == 0) begin
          in_valid = 1'b0;
          @(negedge clk);
        end
      end
      in_valid   = 1'b1;
      in_data    = job_bytes[k];
      done_force = pulse && (k == 5);
      if (k == NBYTES - 1) chk("mult_valid_early", mult_valid, 0);
      @(negedge clk);
    end
    in_valid   = 1'b0;
    done_force = 1'b0;
    chk("mult_valid_rise", mult_valid, 1);
    @(negedge clk);
    chk("mult_valid_pulse", mult_valid, 0);
  endtask

  task automatic check_loaded();
    int errs = 0;
    for (int r = 0; r < D; r++) begin
      if (b_vector[r] !== job_bytes[D*D+r]) errs++;
      for (int c = 0; c < D; c++) if (a_matrix[r][c] !== job_bytes[r*D+c]) errs++;
    end
    chk("loaded_elems_bad", errs, 0);
  endtask

  task automatic drain_job(input bit bp);
    int            got = 0;
    int            cyc = 0;
    bit            held = 1'b0;
    logic [RW-1:0] hd = '0;
    logic          hl = 1'b0;
    logic          r;
    exp_t          e;
    while (done !== 1'b1 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    chk("done_seen", done, 1);
    chk("wait_out_valid", out_valid, 0);
    @(negedge clk);
    chk("done_to_out_valid", out_valid, 1);
    cyc = 0;
    while (got < NWORDS && cyc < 500) begin
      if (held) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_data", out_data, hd);
        chk("hold_last", out_last, hl);
      end
      r = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      out_ready = r;
      if (out_valid && r) begin
        e = exp_q.pop_front();
        chk("out_data", out_data, e.d);
        chk("out_last", out_last, e.l);
        got++;
        held = 1'b0;
      end else if (out_valid) begin
        held = 1'b1;
        hd   = out_data;
        hl   = out_last;
      end
      @(negedge clk);
      cyc++;
    end
    out_ready = 1'b0;
    chk("drain_words", got, NWORDS);
  endtask

  task automatic run_job(input bit gaps, input bit bp, input bit pulse);
    push_expected();
    send_job(gaps, pulse);
    check_loaded();
    drain_job(bp);
    chk("eng_rst_c1", eng_rst_n, 0);
    chk("post_drain_valid", out_valid, 0);
    @(negedge clk);
    chk("eng_rst_c2", eng_rst_n, 0);
    chk("eng_rst_in_ready", in_ready, 0);
    @(negedge clk);
    chk("eng_rst_release", eng_rst_n, 1);
    chk("restart_in_ready", in_ready, 1);
  endtask

  initial begin
    int errs;
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    in_data    = '0;
    out_ready  = 1'b0;
    done_force = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_mult_valid", mult_valid, 0);
    chk("rst_eng_rst_n", eng_rst_n, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_last", out_last, 0);
    errs = 0;
    for (int r = 0; r < D; r++) begin
      if (b_vector[r] !== '0) errs++;
      for (int c = 0; c < D; c++) if (a_matrix[r][c] !== '0) errs++;
    end
    chk("rst_arrays_nonzero", errs, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("eng_rst_n_idle", eng_rst_n, 1);

    // Identity matrix, b = 1..8
    for (int k = 0; k < NBYTES; k++)
      job_bytes[k] = (k < D * D) ? DW'((k / D) == (k % D)) : DW'(k - D * D + 1);
    run_job(1'b0, 1'b0, 1'b0);

    // All 0xFF, with output backpressure
    for (int k = 0; k < NBYTES; k++) job_bytes[k] = 8'hFF;
    run_job(1'b0, 1'b1, 1'b0);

    // A[r][c] = r*8+c, random b, input gaps and backpressure
    for (int k = 0; k < NBYTES; k++)
      job_bytes[k] = (k < D * D) ? DW'(k) : DW'($urandom_range(0, 255));
    run_job(1'b1, 1'b1, 1'b0);

    // Reset after 10 bytes of a job, then a fresh job
    for (int k = 0; k < 10; k++) begin
      in_valid = 1'b1;
      in_data  = DW'(8'hA0 + k);
      @(negedge clk);
    end
    in_valid = 1'b0;
    rst_n    = 1'b0;
    @(negedge clk);
    chk("midrst_a00", a_matrix[0][0], 0);
    chk("midrst_eng_rst_n", eng_rst_n, 0);
    chk("midrst_in_ready", in_ready, 1);
    rst_n = 1'b1;
    @(negedge clk);
    for (int k = 0; k < NBYTES; k++) job_bytes[k] = DW'($urandom_range(0, 255));
    run_job(1'b1, 1'b0, 1'b0);

    // Back-to-back jobs; stray done pulse during the second load
    for (int k = 0; k < NBYTES; k++) job_bytes[k] = DW'(3 * k + 7);
    run_job(1'b0, 1'b0, 1'b0);
    for (int k = 0; k < NBYTES; k++) job_bytes[k] = DW'($urandom_range(0, 255));
    run_job(1'b0, 1'b1, 1'b1);

    chk("scoreboard_left", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
